sdram_port_arbiter: RTL and testbench
=====================================

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, SDRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, SDRAM data width.
REQ-003 SHALL have parameter TMO_CYC, default 256, response-timeout limit in cycles.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports pN_req  input  1  request level from requester N, N in {0,1}.
REQ-007 SHALL have ports pN_we  input  1  1=write, 0=read; held with pN_req.
REQ-008 SHALL have ports pN_addr  input  ADDR_W  and pN_wdata  input  DATA_W; both held with pN_req.
REQ-009 SHALL have ports pN_ack  output  1  one-cycle pulse when the pN command is issued to SDRAM.
REQ-010 SHALL have ports pN_rdata  output  DATA_W  and pN_rvalid  output  1  read return, one-cycle pulse.
REQ-011 SHALL have ports pN_err  output  1  one-cycle timeout pulse.
REQ-012 SHALL have ports ctrl_addr  output  ADDR_W,  ctrl_wr_data  output  DATA_W,  ctrl_rd_req  output  1,  ctrl_wr_req  output  1  for the SDRAM controller command.
REQ-013 SHALL have ports ctrl_rd_data  input  DATA_W,  ctrl_rd_valid  input  1,  ctrl_ready  input  1 (controller idle, able to accept a command).
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WR_WAIT and RD_WAIT.
REQ-016 SHALL, in IDLE with ctrl_ready=1 and any pN_req=1, select a winner, capture its we/addr/wdata and owner, and go to ISSUE; with ctrl_ready=0 it SHALL stay in IDLE.
REQ-017 SHALL arbitrate round-robin: a sole requester wins; when both request, the port not granted last wins; after reset port 0 has priority.
REQ-018 SHALL, in ISSUE, drive ctrl_rd_req or ctrl_wr_req high for exactly one cycle with captured ctrl_addr/ctrl_wr_data, pulse the owner's pN_ack in the same cycle, and record the owner as last granted.
REQ-019 SHALL require the requester to drop pN_req the cycle after pN_ack; a request still high in the following IDLE is a new transaction.
REQ-020 SHALL go from ISSUE to WR_WAIT on a write, and from ISSUE to RD_WAIT on a read.
REQ-021 SHALL, in WR_WAIT, first observe ctrl_ready=0, then return to IDLE on the first following ctrl_ready=1.
REQ-022 SHALL, in RD_WAIT on ctrl_rd_valid=1, register ctrl_rd_data into the owner's pN_rdata, pulse pN_rvalid one cycle later (1-cycle latency), and return to IDLE.
REQ-023 SHALL hold ctrl_addr/ctrl_wr_data stable from ISSUE until return to IDLE; pN_rdata SHALL hold until the next read return for port N.
REQ-024 SHALL ignore ctrl_rd_valid outside RD_WAIT.
REQ-025 SHALL never have ctrl_rd_req and ctrl_wr_req high simultaneously, nor more than one transaction outstanding.
REQ-026 SHALL ignore requests arriving outside IDLE; they are served on the next IDLE evaluation.

Reset
REQ-027 SHALL, while rst=1 (asynchronous, at any state, including mid-transaction), force state IDLE, last-granted=port 1, timeout counter 0, and all outputs 0 (pN_ack, pN_rvalid, pN_err, pN_rdata, ctrl_*, busy); in-flight transactions are abandoned without ack or rvalid.

Configuration
REQ-028 SHALL, with macro SDRAM_ARB_TIMEOUT_EN defined, count cycles spent in WR_WAIT/RD_WAIT (cleared on entry) and, on reaching TMO_CYC, pulse the owner's pN_err one cycle and return to IDLE with no rvalid.
REQ-029 SHALL, without SDRAM_ARB_TIMEOUT_EN, omit the counter, tie pN_err to 0, and wait indefinitely in WR_WAIT/RD_WAIT.

Verification
REQ-030 SHALL verify a single read: p0 read addr 0x000123, ctrl_rd_data=0xBEEF -> one ctrl_rd_req pulse with ctrl_addr=0x000123, p0_ack, then p0_rvalid with p0_rdata=0xBEEF one cycle after ctrl_rd_valid.
REQ-031 SHALL verify a single write: p1 write addr 0x00ABCD data 0x1234 -> one ctrl_wr_req pulse with matching ctrl_addr/ctrl_wr_data, p1_ack, busy until ctrl_ready goes 0 then 1.
REQ-032 SHALL verify arbitration: both ports request continuously from reset -> grants 0,1,0,1; no overlap of transactions.
REQ-033 SHALL verify stall: ctrl_ready=0 held 20 cycles with p0_req=1 -> no ctrl_*_req and no ack until ctrl_ready=1.
REQ-034 SHALL verify reset mid-read: rst asserted in RD_WAIT -> all outputs 0 immediately; a late ctrl_rd_valid produces no pN_rvalid.
REQ-035 SHALL verify timeout: with SDRAM_ARB_TIMEOUT_EN and TMO_CYC=256, read with no ctrl_rd_valid -> p0_err pulse after 256 cycles and return to IDLE; without the macro, p0_err stays 0.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle between two SDRAM requesters, the port arbiter and the SDRAM controller.
// slave = arbiter view, master = requester/controller (testbench) view.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic              p0_req, p0_we, p0_ack, p0_rvalid, p0_err;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata, p0_rdata;

    logic              p1_req, p1_we, p1_ack, p1_rvalid, p1_err;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata, p1_rdata;

    logic [ADDR_W-1:0] ctrl_addr;
    logic [DATA_W-1:0] ctrl_wr_data, ctrl_rd_data;
    logic              ctrl_rd_req, ctrl_wr_req, ctrl_rd_valid, ctrl_ready;
    logic              busy;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  ctrl_rd_data, ctrl_rd_valid, ctrl_ready,
        output p0_ack, p0_rvalid, p0_err, p0_rdata,
        output p1_ack, p1_rvalid, p1_err, p1_rdata,
        output ctrl_addr, ctrl_wr_data, ctrl_rd_req, ctrl_wr_req, busy
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output ctrl_rd_data, ctrl_rd_valid, ctrl_ready,
        input  p0_ack, p0_rvalid, p0_err, p0_rdata,
        input  p1_ack, p1_rvalid, p1_err, p1_rdata,
        input  ctrl_addr, ctrl_wr_data, ctrl_rd_req, ctrl_wr_req, busy
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-command SDRAM controller.
// Define SDRAM_ARB_TIMEOUT_EN to add a response timeout (pN_err) on the wait states.
module sdram_port_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int TMO_CYC = 256
) (
    input  logic clk,
    input  logic rst,
    sdram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WR_WAIT, RD_WAIT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        req;
    logic              win, owner_q, last_q, we_q, wr_seen_q, tmo_hit;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0][DATA_W-1:0] rdata_q;
    logic [1:0]        rvalid_q;

    assign req = {bus.p1_req, bus.p0_req};
    // Sole requester wins; on contention the port not granted last goes next.
    assign win = (req == 2'b11) ? ~last_q : req[1];

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TMO_CYC + 1);
    logic [CNT_W-1:0] tmo_cnt_q;
    logic [1:0]       err_q;

    assign tmo_hit = (state_q == WR_WAIT || state_q == RD_WAIT) &&
                     (tmo_cnt_q == CNT_W'(TMO_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            err_q     <= '0;
        end else begin
            err_q <= '0;
            if (state_q == ISSUE)
                tmo_cnt_q <= '0;
            else if (state_q == WR_WAIT || state_q == RD_WAIT)
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            // A read return in the same cycle as the limit wins over the timeout.
            if (tmo_hit && !(state_q == RD_WAIT && bus.ctrl_rd_valid))
                err_q[owner_q] <= 1'b1;
        end
    end

    assign bus.p0_err = err_q[0];
    assign bus.p1_err = err_q[1];
`else
    assign tmo_hit    = 1'b0;
    assign bus.p0_err = 1'b0;
    assign bus.p1_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.ctrl_ready && |req) state_d = ISSUE;
            ISSUE:   state_d = we_q ? WR_WAIT : RD_WAIT;
            WR_WAIT: if (tmo_hit || (wr_seen_q && bus.ctrl_ready)) state_d = IDLE;
            RD_WAIT: if (bus.ctrl_rd_valid || tmo_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            wr_seen_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rvalid_q  <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= '0;
            case (state_q)
                IDLE: if (state_d == ISSUE) begin
                    owner_q <= win;
                    we_q    <= win ? bus.p1_we    : bus.p0_we;
                    addr_q  <= win ? bus.p1_addr  : bus.p0_addr;
                    wdata_q <= win ? bus.p1_wdata : bus.p0_wdata;
                end
                ISSUE: begin
                    last_q    <= owner_q;
                    wr_seen_q <= 1'b0;
                end
                // Controller must be seen busy before its ready means the write is done.
                WR_WAIT: if (!bus.ctrl_ready) wr_seen_q <= 1'b1;
                RD_WAIT: if (bus.ctrl_rd_valid) begin
                    rdata_q[owner_q]  <= bus.ctrl_rd_data;
                    rvalid_q[owner_q] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.ctrl_rd_req  = (state_q == ISSUE) && !we_q;
    assign bus.ctrl_wr_req  = (state_q == ISSUE) &&  we_q;
    assign bus.ctrl_addr    = addr_q;
    assign bus.ctrl_wr_data = wdata_q;
    assign bus.p0_ack       = (state_q == ISSUE) && !owner_q;
    assign bus.p1_ack       = (state_q == ISSUE) &&  owner_q;
    assign bus.p0_rvalid    = rvalid_q[0];
    assign bus.p1_rvalid    = rvalid_q[1];
    assign bus.p0_rdata     = rdata_q[0];
    assign bus.p1_rdata     = rdata_q[1];
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: table of single transactions plus
// hand sequences for stall, contention, reset mid-read and timeout.
module tb_sdram_port_arbiter;
    localparam int ADDR_W = 24, DATA_W = 16, TMO_CYC = 256;

    logic CLOCK_50 = 1'b0;
    logic rst = 1'b1;
    always #10 CLOCK_50 = ~CLOCK_50;

    sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
    sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_CYC(TMO_CYC)) dut (
        .clk(CLOCK_50), .rst(rst), .bus(bus.slave)
    );

    int tests = 0, fails = 0;

    typedef struct {
        logic [1:0]        req, we;
        logic [ADDR_W-1:0] a0, a1;
        logic [DATA_W-1:0] w0, w1, rd;
        logic              e_port, e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata, e_rdata;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drop_reqs();
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    endtask

    task automatic wait_ack(output bit got);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            if (bus.p0_ack || bus.p1_ack) begin got = 1'b1; break; end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit got;
        @(posedge CLOCK_50); #1;
        bus.p0_req = v.req[0]; bus.p0_we = v.we[0]; bus.p0_addr = v.a0; bus.p0_wdata = v.w0;
        bus.p1_req = v.req[1]; bus.p1_we = v.we[1]; bus.p1_addr = v.a1; bus.p1_wdata = v.w1;
        bus.ctrl_ready = 1'b1;
        wait_ack(got);
        chk($sformatf("v%0d_issue", idx), 32'(got), 32'd1);
        if (!got) begin drop_reqs(); return; end
        chk($sformatf("v%0d_ack", idx), {30'd0, bus.p1_ack, bus.p0_ack}, v.e_port ? 32'd2 : 32'd1);
        chk($sformatf("v%0d_cmd", idx), {30'd0, bus.ctrl_wr_req, bus.ctrl_rd_req}, v.e_we ? 32'd2 : 32'd1);
        chk($sformatf("v%0d_addr", idx), 32'(bus.ctrl_addr), 32'(v.e_addr));
        if (v.e_we) chk($sformatf("v%0d_wdata", idx), 32'(bus.ctrl_wr_data), 32'(v.e_wdata));
        @(posedge CLOCK_50); #1; drop_reqs();
        @(negedge CLOCK_50);
        chk($sformatf("v%0d_pulse", idx),
            {28'd0, bus.p1_ack, bus.p0_ack, bus.ctrl_wr_req, bus.ctrl_rd_req}, 32'd0);
        if (!v.e_we) begin
            @(posedge CLOCK_50); #1; bus.ctrl_rd_valid = 1'b1; bus.ctrl_rd_data = v.rd;
            @(negedge CLOCK_50);
            chk($sformatf("v%0d_rv_lat", idx), {30'd0, bus.p1_rvalid, bus.p0_rvalid}, 32'd0);
            @(posedge CLOCK_50); #1; bus.ctrl_rd_valid = 1'b0; bus.ctrl_rd_data = 16'hDEAD;
            @(negedge CLOCK_50);
            chk($sformatf("v%0d_rvalid", idx), {30'd0, bus.p1_rvalid, bus.p0_rvalid}, v.e_port ? 32'd2 : 32'd1);
            chk($sformatf("v%0d_rdata", idx), 32'(v.e_port ? bus.p1_rdata : bus.p0_rdata), 32'(v.e_rdata));
            chk($sformatf("v%0d_rd_done", idx), 32'(bus.busy), 32'd0);
        end else begin
            @(posedge CLOCK_50); @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            chk($sformatf("v%0d_wr_hold", idx), 32'(bus.busy), 32'd1);
            @(posedge CLOCK_50); #1; bus.ctrl_ready = 1'b0;
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            chk($sformatf("v%0d_wr_busy", idx), 32'(bus.busy), 32'd1);
            chk($sformatf("v%0d_addr_hold", idx), 32'(bus.ctrl_addr), 32'(v.e_addr));
            @(posedge CLOCK_50); #1; bus.ctrl_ready = 1'b1;
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            chk($sformatf("v%0d_wr_done", idx), 32'(bus.busy), 32'd0);
        end
    endtask

    function automatic logic [31:0] all_flags();
        return {23'd0, bus.busy, bus.ctrl_rd_req, bus.ctrl_wr_req, bus.p0_ack, bus.p1_ack,
                bus.p0_rvalid, bus.p1_rvalid, bus.p0_err, bus.p1_err};
    endfunction

    initial begin
        bit got, bad, overlap;
        int ngr, err_at, err_cnt;
        logic [3:0] grants;

        //                 req    we     a0          a1          w0        w1        rd        port  we    e_addr      e_wdata   e_rdata
        vecs[0] = '{2'b01, 2'b00, 24'h000123, 24'h0,      16'h0,    16'h0,    16'hBEEF, 1'b0, 1'b0, 24'h000123, 16'h0,    16'hBEEF};
        vecs[1] = '{2'b10, 2'b10, 24'h0,      24'h00ABCD, 16'h0,    16'h1234, 16'h0,    1'b1, 1'b1, 24'h00ABCD, 16'h1234, 16'h0};
        vecs[2] = '{2'b11, 2'b10, 24'h000010, 24'h000020, 16'h0,    16'h5555, 16'hA5A5, 1'b0, 1'b0, 24'h000010, 16'h0,    16'hA5A5};
        vecs[3] = '{2'b11, 2'b10, 24'h000010, 24'h000020, 16'h0,    16'h5555, 16'h0,    1'b1, 1'b1, 24'h000020, 16'h5555, 16'h0};
        vecs[4] = '{2'b01, 2'b01, 24'hFFFFFF, 24'h0,      16'hFFFF, 16'h0,    16'h0,    1'b0, 1'b1, 24'hFFFFFF, 16'hFFFF, 16'h0};
        vecs[5] = '{2'b10, 2'b00, 24'h0,      24'h000000, 16'h0,    16'h0,    16'h0001, 1'b1, 1'b0, 24'h000000, 16'h0,    16'h0001};
        vecs[6] = '{2'b11, 2'b00, 24'h111111, 24'h222222, 16'h0,    16'h0,    16'h7777, 1'b0, 1'b0, 24'h111111, 16'h0,    16'h7777};
        vecs[7] = '{2'b11, 2'b11, 24'h333333, 24'h444444, 16'h0F0F, 16'hF0F0, 16'h0,    1'b1, 1'b1, 24'h444444, 16'hF0F0, 16'h0};

        bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
        bus.ctrl_rd_data = '0; bus.ctrl_rd_valid = 0; bus.ctrl_ready = 1;

        #5;
        chk("reset_flags", all_flags(), 32'd0);
        chk("reset_addr", 32'(bus.ctrl_addr), 32'd0);
        @(posedge CLOCK_50); @(posedge CLOCK_50); #1; rst = 1'b0;
        @(negedge CLOCK_50);
        chk("post_reset_idle", all_flags(), 32'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Read return outside RD_WAIT must be ignored; rdata holds.
        @(posedge CLOCK_50); #1; bus.ctrl_rd_valid = 1'b1; bus.ctrl_rd_data = 16'h9999;
        @(posedge CLOCK_50); #1; bus.ctrl_rd_valid = 1'b0;
        @(negedge CLOCK_50);
        chk("stray_rvalid", {30'd0, bus.p1_rvalid, bus.p0_rvalid}, 32'd0);
        chk("p0_rdata_hold", 32'(bus.p0_rdata), 32'h7777);
        chk("p1_rdata_hold", 32'(bus.p1_rdata), 32'h0001);

        // Stall: controller not ready for 20 cycles.
        @(posedge CLOCK_50); #1;
        bus.ctrl_ready = 1'b0; bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 24'h000055;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50);
            if (bus.ctrl_rd_req || bus.ctrl_wr_req || bus.p0_ack || bus.p1_ack || bus.busy) bad = 1'b1;
        end
        chk("stall_quiet", 32'(bad), 32'd0);
        @(posedge CLOCK_50); #1; bus.ctrl_ready = 1'b1;
        wait_ack(got);
        chk("stall_release", {30'd0, got, bus.ctrl_rd_req}, 32'd3);
        @(posedge CLOCK_50); #1; drop_reqs(); bus.ctrl_rd_valid = 1'b1; bus.ctrl_rd_data = 16'h4242;
        @(posedge CLOCK_50); #1; bus.ctrl_rd_valid = 1'b0;
        @(negedge CLOCK_50);
        chk("stall_read", {15'd0, bus.p0_rvalid, bus.p0_rdata}, {15'd0, 1'b1, 16'h4242});

        // Both ports request continuously from reset: grants alternate 0,1,0,1.
        @(posedge CLOCK_50); #1; rst = 1'b1;
        @(posedge CLOCK_50); #1; rst = 1'b0;
        bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 24'h000A00;
        bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 24'h000B00;
        ngr = 0; overlap = 1'b0; grants = '0;
        for (int i = 0; i < 60 && ngr < 4; i++) begin
            @(negedge CLOCK_50);
            if ((bus.p0_ack && bus.p1_ack) || (bus.ctrl_rd_req && bus.ctrl_wr_req)) overlap = 1'b1;
            if (bus.p0_ack || bus.p1_ack) begin
                if (!bus.ctrl_rd_req || bus.ctrl_addr != (bus.p1_ack ? 24'h000B00 : 24'h000A00)) overlap = 1'b1;
                grants[ngr] = bus.p1_ack;
                ngr++;
            end
            bus.ctrl_rd_valid = bus.busy && !bus.ctrl_rd_req;
        end
        chk("arb_count", 32'(ngr), 32'd4);
        chk("arb_order", 32'(grants), 32'b1010);
        chk("arb_overlap", 32'(overlap), 32'd0);
        drop_reqs();
        @(posedge CLOCK_50); #1; bus.ctrl_rd_valid = 1'b1;
        @(posedge CLOCK_50); #1; bus.ctrl_rd_valid = 1'b0;

        // Reset in RD_WAIT: outputs clear at once; a late read return is dropped.
        @(posedge CLOCK_50); #1;
        bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 24'h00C0DE; bus.p1_wdata = 16'h5A5A;
        wait_ack(got);
        chk("rst_mid_issue", 32'(got), 32'd1);
        @(posedge CLOCK_50); #1; drop_reqs();
        @(posedge CLOCK_50); #3; rst = 1'b1;
        #1;
        chk("rst_mid_flags", all_flags(), 32'd0);
        chk("rst_mid_ctrl", {bus.ctrl_wr_data, 8'd0, bus.ctrl_addr[7:0]}, 32'd0);
        chk("rst_mid_rdata", {bus.p1_rdata, bus.p0_rdata}, 32'd0);
        bus.ctrl_rd_valid = 1'b1; bus.ctrl_rd_data = 16'hBAD0;
        @(posedge CLOCK_50); #1; rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK_50);
            if (bus.p0_rvalid || bus.p1_rvalid || bus.busy) bad = 1'b1;
        end
        bus.ctrl_rd_valid = 1'b0;
        chk("rst_late_valid", 32'(bad), 32'd0);

        // Read with no return: 256 cycles in RD_WAIT, then err (or wait forever).
        @(posedge CLOCK_50); #1;
        bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 24'h0000FF;
        wait_ack(got);
        chk("tmo_issue", 32'(got), 32'd1);
        drop_reqs();
        err_at = 0; err_cnt = 0; bad = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge CLOCK_50);
            if (bus.p0_err) begin err_cnt++; if (err_at == 0) err_at = k; end
            if (bus.p0_rvalid || bus.p1_err) bad = 1'b1;
        end
        chk("tmo_no_rvalid", 32'(bad), 32'd0);
`ifdef SDRAM_ARB_TIMEOUT_EN
        chk("tmo_err_at", 32'(err_at), 32'd257);
        chk("tmo_err_pulse", 32'(err_cnt), 32'd1);
        chk("tmo_idle", 32'(bus.busy), 32'd0);
`else
        chk("tmo_err_none", 32'(err_cnt), 32'd0);
        chk("tmo_still_busy", 32'(bus.busy), 32'd1);
`endif
        @(posedge CLOCK_50); #1; rst = 1'b1;
        @(posedge CLOCK_50); #1; rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
